// File: rtl/cnt_seq_checker_if.sv
// Bus bundle between a counter-state source and the sequence checker.
// The master drives the sampled state and control strobes; the slave
// (the checker) returns lock status, error pulse, prediction and counters.
interface cnt_seq_checker_if #(
  parameter int CW = 8
);
  logic          sample_en;
  logic [1:0]    y_in;
  logic          cnt_clr;
  logic          locked;
  logic          err;
  logic [1:0]    expected;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] match_cnt;
  logic          illegal;

  modport master (
    output sample_en, y_in, cnt_clr,
    input  locked, err, expected, err_cnt, match_cnt, illegal
  );

  modport slave (
    input  sample_en, y_in, cnt_clr,
    output locked, err, expected, err_cnt, match_cnt, illegal
  );
endinterface

// File: rtl/cnt_seq_checker.sv
// Receive-side checker for the 2-bit T-flip-flop state counter {A,B}.
// Predicts each next state from the counter's fixed next-state function,
// locks after LOCK_LEN consecutive legal transitions, then pulses err and
// counts every deviation; UNLOCK_LEN consecutive deviations drop lock.
// Optional build macro: CNT_SEQ_CHK_ILLEGAL_EN -- when defined, a sampled
// state of 11 sets the sticky illegal flag and always counts as a mismatch.
module cnt_seq_checker #(
  parameter int LOCK_LEN   = 4,
  parameter int UNLOCK_LEN = 2,
  parameter int CW         = 8
) (
  input logic               clk,
  input logic               rst,
  cnt_seq_checker_if.slave  bus
);

  localparam int GW = $clog2(LOCK_LEN + 1);
  localparam int MW = $clog2(UNLOCK_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    prev_q, prev_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [1:0]    expected_q, expected_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d;
  logic          illegal_q, illegal_d;

  logic          is_match;
  logic          is_illegal;
  logic [GW-1:0] good_inc;
  logic [MW-1:0] miss_inc;

  // Counter next-state function; 11 is not a real state and falls back to 00.
  function automatic logic [1:0] next_of(input logic [1:0] s);
    case (s)
      2'b00:   next_of = 2'b01;
      2'b01:   next_of = 2'b10;
      default: next_of = 2'b00;
    endcase
  endfunction

  // Classify the incoming sample against the prediction from the last observed state.
  always_comb begin
`ifdef CNT_SEQ_CHK_ILLEGAL_EN
    is_illegal = (bus.y_in == 2'b11);
    is_match   = (bus.y_in == next_of(prev_q)) && !is_illegal;
`else
    is_illegal = 1'b0;
    is_match   = (bus.y_in == next_of(prev_q));
`endif
    good_inc = good_q + GW'(1);
    miss_inc = miss_q + MW'(1);
  end

  // Next-state and next-output logic; counter clear overrides any increment.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    expected_d  = expected_q;
    err_cnt_d   = err_cnt_q;
    match_cnt_d = match_cnt_q;
    illegal_d   = illegal_q;

    if (bus.sample_en) begin
      prev_d     = bus.y_in;
      expected_d = next_of(bus.y_in);
      if (is_illegal) illegal_d = 1'b1;

      unique case (state_q)
        IDLE: begin
          state_d = TRACK;
          good_d  = '0;
        end
        TRACK: begin
          if (is_match) begin
            good_d = good_inc;
            if (good_inc == GW'(LOCK_LEN)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (is_match) begin
            miss_d = '0;
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CW'(1);
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
            if (miss_inc == MW'(UNLOCK_LEN)) begin
              state_d  = TRACK;
              locked_d = 1'b0;
              good_d   = '0;
              miss_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (bus.cnt_clr) begin
      err_cnt_d   = '0;
      match_cnt_d = '0;
      illegal_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= 2'b00;
      good_q      <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      expected_q  <= 2'b00;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      expected_q  <= expected_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.expected  = expected_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.illegal   = illegal_q;

endmodule
